fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have port clk  in  1  sole clock, rising-edge.
REQ-002 SHALL have port reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL have port boot_addr_i  in  32  first fetch address; sampled while reset is low.
REQ-004 SHALL have port imem_req_o  out  1  instruction-memory request.
REQ-005 SHALL have port imem_addr_o  out  32  request address, word aligned.
REQ-006 SHALL have port imem_gnt_i  in  1  request accepted this cycle.
REQ-007 SHALL have port imem_rvalid_i  in  1  read data valid; responses arrive in order.
REQ-008 SHALL have port imem_rdata_i  in  32  read data.
REQ-009 SHALL have port redirect_i  in  1  branch/jump redirect pulse.
REQ-010 SHALL have port redirect_pc_i  in  32  redirect target.
REQ-011 SHALL have port instr_o  out  32  instruction to ifu instruction_i.
REQ-012 SHALL have port instr_pc_o  out  32  PC of instr_o.
REQ-013 SHALL have port instr_valid_o  out  1  instr_o/instr_pc_o valid.
REQ-014 SHALL have port instr_ready_i  in  1  consumer accepts; transfer = valid & ready.
REQ-015 SHALL have port fetch_err_o  out  1  sticky misaligned-redirect error (see Configuration).

Function
REQ-016 SHALL hold at most one outstanding memory transaction (granted, response not yet received).
REQ-017 SHALL buffer responses in a 2-entry FIFO of {instr, pc}; head drives instr_o/instr_pc_o.
REQ-018 SHALL implement FSM states IDLE, REQ, WAIT, HALT.
REQ-019 SHALL leave IDLE to REQ on the first clk edge after reset deasserts, with fetch_pc = boot_addr_i.
REQ-020 SHALL assert imem_req_o only in REQ, and enter REQ only when FIFO occupancy < 2; otherwise remain in IDLE.
REQ-021 SHALL hold imem_req_o high and imem_addr_o stable in REQ until imem_gnt_i; on grant go to WAIT and set fetch_pc += 4 (mod 2^32, wraps 0xFFFFFFFC -> 0x00000000).
REQ-022 SHALL, in WAIT, on imem_rvalid_i push {imem_rdata_i, request address} into the FIFO, then go to REQ if space remains after any same-cycle pop, else IDLE.
REQ-023 SHALL show a pushed entry on instr_valid_o the cycle after the rvalid edge (1-cycle latency).
REQ-024 SHALL accept a push and a pop on the same edge when full (occupancy unchanged).
REQ-025 SHALL, on redirect_i, flush the FIFO (instr_valid_o low next cycle) and set fetch_pc = redirect_pc_i.
REQ-026 SHALL, on redirect in REQ before grant, keep the old request until granted, mark it discard, then issue at redirect_pc_i.
REQ-027 SHALL, on redirect in WAIT, or in REQ on the grant cycle, drop the pending response (no FIFO push) and then request redirect_pc_i.
REQ-028 SHALL let redirect_i win over a same-cycle instr_ready_i or rvalid push; a later redirect overrides an earlier pending target.
REQ-029 SHALL never present imem_addr_o with bits [1:0] != 0.

Reset
REQ-030 SHALL, while reset is low, force state IDLE, FIFO empty, discard flag 0, fetch_pc = boot_addr_i, and outputs imem_req_o=0, imem_addr_o=0, instr_o=0, instr_pc_o=0, instr_valid_o=0, fetch_err_o=0.
REQ-031 SHALL, on reset mid-transaction, abandon the outstanding request and restart from boot_addr_i; a post-reset rvalid without a grant is ignored.

Configuration
REQ-032 SHALL, with macro FETCH_MISALIGN_CHK_EN defined, treat a redirect with redirect_pc_i[1:0] != 0 as an error: set fetch_err_o, flush the FIFO, enter HALT (no requests) until reset; an outstanding response is dropped.
REQ-033 SHALL, without FETCH_MISALIGN_CHK_EN, clear redirect_pc_i[1:0] to 0, tie fetch_err_o to 0, and make HALT unreachable.

Verification
REQ-034 SHALL cover boot: boot_addr_i=0x00000100, gnt and rvalid 1 cycle after each req, ready=1 -> addresses 0x100, 0x104, 0x108; instr_pc_o matches each instruction.
REQ-035 SHALL cover back-pressure: ready=0, memory returns 0x00345678 then 0x00345478 -> FIFO full, imem_req_o low; one ready pulse -> exactly one new request.
REQ-036 SHALL cover redirect in WAIT: request 0x104 outstanding, redirect to 0x200 -> 0x104 data never appears; next request is 0x200.
REQ-037 SHALL cover redirect in REQ with gnt held low 3 cycles -> imem_addr_o stays at the old address until grant, response dropped, then 0x200 requested.
REQ-038 SHALL cover wrap: boot 0xFFFFFFFC -> next request 0x00000000.
REQ-039 SHALL cover, with FETCH_MISALIGN_CHK_EN, redirect to 0x00000202 -> fetch_err_o=1, no further requests until reset; without the macro -> request at 0x00000200.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch controller. It keeps one imem transaction in flight and buffers {instr, pc} in a 2-entry FIFO.
// Optional feature: define FETCH_MISALIGN_CHK_EN to halt with fetch_err_o on a misaligned redirect target.
`timescale 1ns/1ps
module fetch_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] boot_addr_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic        fetch_err_o
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HALT
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] redir_pc_q, redir_pc_d;
    logic        redir_pend_q, redir_pend_d;
    logic        discard_q, discard_d;
    logic        err_q, err_d;

    logic [31:0] fifo_instr_q [2];
    logic [31:0] fifo_pc_q    [2];
    logic        rd_ptr_q, wr_ptr_q;
    logic [1:0]  count_q, count_d;

    logic        push, pop, flush, misalign;
    logic [31:0] redir_tgt;

    assign redir_tgt = redirect_pc_i & 32'hFFFF_FFFC;
    assign flush     = redirect_i && (state_q != HALT);

`ifdef FETCH_MISALIGN_CHK_EN
    assign misalign = flush && (redirect_pc_i[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Response FIFO
    // ------------------------------------------------------------------
    assign instr_valid_o = (count_q != 2'd0);
    assign pop           = instr_valid_o && instr_ready_i && !flush;
    assign push          = (state_q == WAIT) && imem_rvalid_i && !discard_q && !flush;
    assign instr_o       = instr_valid_o ? fifo_instr_q[rd_ptr_q] : '0;
    assign instr_pc_o    = instr_valid_o ? fifo_pc_q[rd_ptr_q]    : '0;
    assign fetch_err_o   = err_q;

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                fifo_instr_q[i] <= '0;
                fifo_pc_q[i]    <= '0;
            end
        end else begin
            count_q <= count_d;
            if (flush) begin
                rd_ptr_q <= 1'b0;
                wr_ptr_q <= 1'b0;
            end else begin
                if (push) begin
                    fifo_instr_q[wr_ptr_q] <= imem_rdata_i;
                    fifo_pc_q[wr_ptr_q]    <= out_pc_q;
                    wr_ptr_q               <= ~wr_ptr_q;
                end
                if (pop) begin
                    rd_ptr_q <= ~rd_ptr_q;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Fetch FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        out_pc_d     = out_pc_q;
        redir_pc_d   = redir_pc_q;
        redir_pend_d = redir_pend_q;
        discard_d    = discard_q;
        err_d        = err_q;
        imem_req_o   = 1'b0;
        imem_addr_o  = '0;

        case (state_q)
            IDLE: begin
                if (redirect_i) begin
                    fetch_pc_d = redir_tgt;
                end
                if (count_d < 2'd2) begin
                    state_d = REQ;
                end
            end

            REQ: begin
                imem_req_o  = 1'b1;
                imem_addr_o = fetch_pc_q;
                if (imem_gnt_i) begin
                    out_pc_d     = fetch_pc_q;
                    state_d      = WAIT;
                    redir_pend_d = 1'b0;
                    if (redirect_i) begin
                        fetch_pc_d = redir_tgt;
                        discard_d  = 1'b1;
                    end else if (redir_pend_q) begin
                        fetch_pc_d = redir_pc_q;
                    end else begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                    end
                end else if (redirect_i) begin
                    // The address must stay stable until granted, so the target waits aside.
                    redir_pend_d = 1'b1;
                    redir_pc_d   = redir_tgt;
                    discard_d    = 1'b1;
                end
            end

            WAIT: begin
                if (redirect_i) begin
                    fetch_pc_d = redir_tgt;
                end
                if (imem_rvalid_i) begin
                    discard_d = 1'b0;
                    state_d   = (count_d < 2'd2) ? REQ : IDLE;
                end else if (redirect_i) begin
                    discard_d = 1'b1;
                end
            end

            HALT: begin
                state_d = HALT;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (misalign) begin
            state_d      = HALT;
            err_d        = 1'b1;
            discard_d    = 1'b0;
            redir_pend_d = 1'b0;
        end
    end

    // The boot address is captured continuously while reset is held low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            fetch_pc_q   <= boot_addr_i & 32'hFFFF_FFFC;
            out_pc_q     <= '0;
            redir_pc_q   <= '0;
            redir_pend_q <= 1'b0;
            discard_q    <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            out_pc_q     <= out_pc_d;
            redir_pc_q   <= redir_pc_d;
            redir_pend_q <= redir_pend_d;
            discard_q    <= discard_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: a boot vector table, directed multi-cycle corner sequences, and a randomized run
// checked against an instruction-stream model (expected next PC, data derived from address).
`timescale 1ns/1ps
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] boot_addr_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic        fetch_err_o;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .boot_addr_i   (boot_addr_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .fetch_err_o   (fetch_err_o)
    );

    typedef struct {
        logic        gnt;
        logic        rvalid;
        logic        ready;
        logic [31:0] rdata;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t        vecs [10];
    logic [31:0] pend [$];
    int unsigned rsp_wait;
    logic [31:0] exp_next;
    logic        redir_prev;
    int unsigned delivered;
    logic [31:0] tgt;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic idle_inputs();
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
    endtask

    task automatic do_reset(input logic [31:0] boot);
        idle_inputs();
        instr_ready_i = 1'b0;
        boot_addr_i   = boot;
        reset         = 1'b0;
        #1;
        check1("rst_err_async", fetch_err_o, 1'b0);
        cycle();
        cycle();
        check1("rst_req", imem_req_o, 1'b0);
        check32("rst_addr", imem_addr_o, 32'd0);
        check1("rst_valid", instr_valid_o, 1'b0);
        check32("rst_instr", instr_o, 32'd0);
        check32("rst_pc", instr_pc_o, 32'd0);
        check1("rst_err", fetch_err_o, 1'b0);
        reset = 1'b1;
    endtask

    task automatic wait_req(input string name, input logic [31:0] addr);
        int unsigned n;
        n = 0;
        while (!imem_req_o && n < 20) begin
            cycle();
            n++;
        end
        check1({name, "_seen"}, imem_req_o, 1'b1);
        check32(name, imem_addr_o, addr);
    endtask

    task automatic grant();
        imem_gnt_i = 1'b1;
        cycle();
        imem_gnt_i = 1'b0;
    endtask

    task automatic respond(input logic [31:0] data);
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = data;
        cycle();
        imem_rvalid_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // gnt, rvalid, ready, rdata | req, addr, valid, instr, pc
        vecs[0] = '{1'b0, 1'b0, 1'b1, 32'h0,         1'b1, 32'h100, 1'b0, 32'h0,         32'h0};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 32'h0,         1'b1, 32'h100, 1'b0, 32'h0,         32'h0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 32'hAAAA_0100, 1'b0, 32'h0,   1'b0, 32'h0,         32'h0};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 32'h0,         1'b1, 32'h104, 1'b1, 32'hAAAA_0100, 32'h100};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 32'h0,         1'b1, 32'h104, 1'b0, 32'h0,         32'h0};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 32'hAAAA_0104, 1'b0, 32'h0,   1'b0, 32'h0,         32'h0};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 32'h0,         1'b1, 32'h108, 1'b1, 32'hAAAA_0104, 32'h104};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 32'h0,         1'b1, 32'h108, 1'b0, 32'h0,         32'h0};
        vecs[8] = '{1'b0, 1'b1, 1'b1, 32'hAAAA_0108, 1'b0, 32'h0,   1'b0, 32'h0,         32'h0};
        vecs[9] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h10C, 1'b1, 32'hAAAA_0108, 32'h108};

        idle_inputs();
        instr_ready_i = 1'b0;
        boot_addr_i   = '0;
        reset         = 1'b0;

        // Boot stream
        do_reset(32'h0000_0100);
        for (int unsigned i = 0; i < 10; i++) begin
            cycle();
            imem_gnt_i    = vecs[i].gnt;
            imem_rvalid_i = vecs[i].rvalid;
            imem_rdata_i  = vecs[i].rdata;
            instr_ready_i = vecs[i].ready;
            check1($sformatf("vec%0d_req", i), imem_req_o, vecs[i].exp_req);
            if (vecs[i].exp_req) check32($sformatf("vec%0d_addr", i), imem_addr_o, vecs[i].exp_addr);
            check1($sformatf("vec%0d_valid", i), instr_valid_o, vecs[i].exp_valid);
            if (vecs[i].exp_valid) begin
                check32($sformatf("vec%0d_instr", i), instr_o, vecs[i].exp_instr);
                check32($sformatf("vec%0d_pc", i), instr_pc_o, vecs[i].exp_pc);
            end
        end

        // Back-pressure: fill the FIFO, then release one entry
        do_reset(32'h0000_0300);
        wait_req("bp_req0", 32'h300);
        grant();
        respond(32'h0034_5678);
        wait_req("bp_req1", 32'h304);
        grant();
        respond(32'h0034_5478);
        for (int unsigned i = 0; i < 4; i++) begin
            check1("bp_full_noreq", imem_req_o, 1'b0);
            cycle();
        end
        check32("bp_head_instr", instr_o, 32'h0034_5678);
        check32("bp_head_pc", instr_pc_o, 32'h300);
        instr_ready_i = 1'b1;
        cycle();
        instr_ready_i = 1'b0;
        check32("bp_next_instr", instr_o, 32'h0034_5478);
        check32("bp_next_pc", instr_pc_o, 32'h304);
        check1("bp_new_req", imem_req_o, 1'b1);
        check32("bp_new_addr", imem_addr_o, 32'h308);
        grant();
        respond(mem_word(32'h308));
        for (int unsigned i = 0; i < 6; i++) begin
            check1("bp_one_req_only", imem_req_o, 1'b0);
            cycle();
        end

        // Redirect while a response is outstanding
        do_reset(32'h0000_0100);
        instr_ready_i = 1'b1;
        wait_req("rw_req0", 32'h100);
        grant();
        respond(mem_word(32'h100));
        wait_req("rw_req1", 32'h104);
        grant();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h200;
        cycle();
        redirect_i = 1'b0;
        check1("rw_flush", instr_valid_o, 1'b0);
        respond(mem_word(32'h104));
        check1("rw_drop", instr_valid_o, 1'b0);
        wait_req("rw_req2", 32'h200);
        grant();
        respond(mem_word(32'h200));
        check1("rw_valid", instr_valid_o, 1'b1);
        check32("rw_instr", instr_o, mem_word(32'h200));
        check32("rw_pc", instr_pc_o, 32'h200);

        // Redirect while the request is still waiting for grant
        do_reset(32'h0000_0100);
        instr_ready_i = 1'b1;
        wait_req("rr_req0", 32'h100);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h200;
        cycle();
        redirect_i = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            check1("rr_hold_req", imem_req_o, 1'b1);
            check32("rr_hold_addr", imem_addr_o, 32'h100);
            cycle();
        end
        check32("rr_addr_at_gnt", imem_addr_o, 32'h100);
        grant();
        respond(mem_word(32'h100));
        check1("rr_drop", instr_valid_o, 1'b0);
        wait_req("rr_req1", 32'h200);

        // Address wrap
        do_reset(32'hFFFF_FFFC);
        instr_ready_i = 1'b0;
        wait_req("wrap_req0", 32'hFFFF_FFFC);
        grant();
        respond(mem_word(32'hFFFF_FFFC));
        check32("wrap_pc", instr_pc_o, 32'hFFFF_FFFC);
        wait_req("wrap_req1", 32'h0000_0000);

        // Reset in the middle of a transaction
        do_reset(32'h0000_0100);
        wait_req("mr_req0", 32'h100);
        grant();
        boot_addr_i = 32'h400;
        reset       = 1'b0;
        cycle();
        check1("mr_req_low", imem_req_o, 1'b0);
        reset         = 1'b1;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = mem_word(32'h100);
        cycle();
        cycle();
        imem_rvalid_i = 1'b0;
        check1("mr_stale_ignored", instr_valid_o, 1'b0);
        wait_req("mr_restart", 32'h400);

        // Misaligned redirect target
        do_reset(32'h0000_0100);
        wait_req("mis_req0", 32'h100);
        grant();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0202;
        cycle();
        redirect_i = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
        check1("mis_err", fetch_err_o, 1'b1);
        respond(mem_word(32'h100));
        for (int unsigned i = 0; i < 6; i++) begin
            check1("mis_halt_noreq", imem_req_o, 1'b0);
            check1("mis_halt_novalid", instr_valid_o, 1'b0);
            cycle();
        end
        check1("mis_err_sticky", fetch_err_o, 1'b1);
`else
        check1("mis_err", fetch_err_o, 1'b0);
        respond(mem_word(32'h100));
        check1("mis_drop", instr_valid_o, 1'b0);
        wait_req("mis_req1", 32'h200);
`endif

        // Randomized run against the instruction-stream model
        do_reset(32'h0000_1000);
        exp_next   = 32'h1000;
        redir_prev = 1'b0;
        delivered  = 0;
        rsp_wait   = 0;
        pend.delete();
        for (int unsigned cyc = 0; cyc < 3000; cyc++) begin
            cycle();
            if (redir_prev) check1("rnd_flush", instr_valid_o, 1'b0);
            if (imem_req_o) begin
                check32("rnd_align", {30'd0, imem_addr_o[1:0]}, 32'd0);
                check32("rnd_outstanding", 32'(pend.size()), 32'd0);
            end

            imem_rvalid_i = 1'b0;
            imem_rdata_i  = $urandom;
            if (pend.size() > 0) begin
                if (rsp_wait == 0) begin
                    imem_rvalid_i = 1'b1;
                    imem_rdata_i  = mem_word(pend[0]);
                    void'(pend.pop_front());
                end else begin
                    rsp_wait--;
                end
            end
            imem_gnt_i = imem_req_o && ($urandom_range(0, 2) != 0);
            if (imem_gnt_i) begin
                pend.push_back(imem_addr_o);
                rsp_wait = $urandom_range(0, 2);
            end

            instr_ready_i = ($urandom_range(0, 1) == 1);
            redirect_i    = ($urandom_range(0, 29) == 0);
            tgt           = $urandom & 32'h0000_FFFF;
`ifdef FETCH_MISALIGN_CHK_EN
            tgt[1:0] = 2'b00;
`endif
            redirect_pc_i = tgt;

            if (redirect_i) begin
                exp_next = tgt & 32'hFFFF_FFFC;
            end else if (instr_valid_o && instr_ready_i) begin
                check32("rnd_pc", instr_pc_o, exp_next);
                check32("rnd_instr", instr_o, mem_word(exp_next));
                exp_next = exp_next + 32'd4;
                delivered++;
            end
            redir_prev = redirect_i;
        end
        check1("rnd_progress", delivered >= 200, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
